// File: rtl/uart_rx_ctrl.sv
// UART receive control: start-bit detect, mid-bit sampling of start/data/(parity)/stop, byte output.
// Latency: RX_Done_Sig/Frame_Err/Parity_Err rise on the edge after the BPS_CLK cycle that samples the stop bit.
// Backpressure: none; the output strobes are single-cycle and must be captured by the consumer when they fire.
//
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the data bits and the stop bit.
//
// Ports:
//   CLK, RSTn    clock and asynchronous active-low reset
//   RX_Pin_In    raw serial line, asynchronous, idles high
//   RX_En        gates start-bit acceptance only
//   BPS_CLK      one-cycle mid-bit pulse from the baud generator
//   Count_Sig    high while a frame is in progress (runs the baud counter)
//   RX_Data      last correctly received byte
//   RX_Done_Sig  one-cycle pulse when RX_Data updates
//   Frame_Err    one-cycle pulse when the stop bit is sampled low
//   Parity_Err   one-cycle pulse on parity mismatch (tied 0 without UART_RX_PARITY_EN)
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 Frame_Err,
  output logic                 Parity_Err
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t               state_q,   state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 rx_dly_q,  rx_dly_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 count_q,   count_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 done_q,    done_d;
  logic                 ferr_q,    ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
  logic                 perr_q,    perr_d;
`endif

  // Falling edge of the synchronized line; decoded straight from flops so
  // Count_Sig rises within three cycles of the start edge.
  logic h2l;
  assign h2l = rx_dly_q & ~rx_sync_q;

  always_comb begin
    state_d   = state_q;
    rx_meta_d = RX_Pin_In;
    rx_sync_d = rx_meta_q;
    rx_dly_d  = rx_sync_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // BPS_CLK is irrelevant here; only a qualified start edge matters.
        if (h2l && RX_En) begin
          state_d = S_START;
          count_d = 1'b1;
        end
      end

      S_START: begin
        if (BPS_CLK) begin
          if (rx_sync_q) begin
            // Line already back high at mid-start: a glitch, not a frame.
            state_d = S_IDLE;
            count_d = 1'b0;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end
      end

      S_DATA: begin
        if (BPS_CLK) begin
          // LSB arrives first, so shifting right leaves bit 0 at the bottom.
          shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (BPS_CLK) begin
          par_err_d = rx_sync_q ^ (^shift_q) ^ PARITY_ODD;
          state_d   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (BPS_CLK) begin
          // Dropping Count_Sig at mid-stop clears the baud counter early so
          // the next start edge is accepted with no dead time.
          state_d = S_IDLE;
          count_d = 1'b0;
          if (!rx_sync_q) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_err_q) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            done_d = 1'b1;
            data_d = shift_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_dly_q  <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      count_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_dly_q  <= rx_dly_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign Count_Sig   = count_q;
  assign RX_Data     = data_q;
  assign RX_Done_Sig = done_q;
  assign Frame_Err   = ferr_q;

`ifdef UART_RX_PARITY_EN
  assign Parity_Err = perr_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign Parity_Err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: paired with a local baud generator, drives serial frames and
// scoreboards every output strobe against an expected-event queue.
// The bit period is scaled down from 5208 cycles to keep run time short; the DUT is period-agnostic.
module tb_uart_rx_ctrl;

  localparam int BIT_CYC = 208;
  localparam int MID_CYC = 104;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       RX_Pin_In;
  logic       RX_En;
  logic       BPS_CLK;
  logic       Count_Sig;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       Frame_Err;
  logic       Parity_Err;

  always #5 CLK = ~CLK;

  uart_rx_ctrl dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .RX_Pin_In   (RX_Pin_In),
    .RX_En       (RX_En),
    .BPS_CLK     (BPS_CLK),
    .Count_Sig   (Count_Sig),
    .RX_Data     (RX_Data),
    .RX_Done_Sig (RX_Done_Sig),
    .Frame_Err   (Frame_Err),
    .Parity_Err  (Parity_Err)
  );

  // Baud generator: free-runs while Count_Sig is high, pulses at mid-bit.
  int baud_cnt;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                       baud_cnt <= 0;
    else if (!Count_Sig)             baud_cnt <= 0;
    else if (baud_cnt == BIT_CYC-1)  baud_cnt <= 0;
    else                             baud_cnt <= baud_cnt + 1;
  end
  assign BPS_CLK = Count_Sig && (baud_cnt == MID_CYC);

  typedef struct {
    logic [2:0] flags;   // {Parity_Err, Frame_Err, RX_Done_Sig}
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  logic       prev_strobe = 1'b0;

  // Scoreboard: every strobe pops one expectation.
  always @(negedge CLK) begin
    logic strobe;
    exp_t e;
    strobe = RX_Done_Sig | Frame_Err | Parity_Err;
    if (RSTn && strobe) begin
      if (RX_Done_Sig) done_cnt++;
      if (Frame_Err)   ferr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got flags=%b data=%h, required no strobe",
                 {Parity_Err, Frame_Err, RX_Done_Sig}, RX_Data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({Parity_Err, Frame_Err, RX_Done_Sig} !== e.flags) begin
          errors++;
          $display("FAIL strobe_kind: got %b, required %b", {Parity_Err, Frame_Err, RX_Done_Sig}, e.flags);
        end
        checks++;
        if (RX_Data !== e.data) begin
          errors++;
          $display("FAIL rx_data: got %h, required %h", RX_Data, e.data);
        end
        checks++;
        if (Count_Sig !== 1'b0) begin
          errors++;
          $display("FAIL count_drop_at_strobe: got %b, required 0", Count_Sig);
        end
      end
      checks++;
      if (prev_strobe !== 1'b0) begin
        errors++;
        $display("FAIL strobe_width: strobe high for 2+ cycles, required 1");
      end
    end
    prev_strobe = RSTn && strobe;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drives one frame starting at a negedge; optionally records the expected outcome.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_flip, input logic expect_out);
    exp_t e;
    if (expect_out) begin
      if (!stop_bit)     begin e.flags = 3'b010; e.data = model_data; end
      else if (par_flip) begin e.flags = 3'b100; e.data = model_data; end
      else begin e.flags = 3'b001; e.data = d; model_data = d; end
      exp_q.push_back(e);
    end
    RX_Pin_In = 1'b0;
    repeat (BIT_CYC) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_Pin_In = d[i];
      repeat (BIT_CYC) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    RX_Pin_In = (^d) ^ par_flip;   // even parity
    repeat (BIT_CYC) @(negedge CLK);
`endif
    RX_Pin_In = stop_bit;
    repeat (BIT_CYC) @(negedge CLK);
    RX_Pin_In = 1'b1;
  endtask

  task automatic test_reset;
    RSTn = 1'b0; RX_Pin_In = 1'b1; RX_En = 1'b1; model_data = 8'h00;
    repeat (3) @(negedge CLK);
    checks++;
    if ({Count_Sig, RX_Done_Sig, Frame_Err, Parity_Err} !== 4'b0 || RX_Data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got cs=%b done=%b ferr=%b perr=%b data=%h, required all 0",
               Count_Sig, RX_Done_Sig, Frame_Err, Parity_Err, RX_Data);
    end
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);
    checks++;
    if (Count_Sig !== 1'b0) begin
      errors++;
      $display("FAIL idle_count_sig: got %b, required 0", Count_Sig);
    end
  endtask

  task automatic test_basic;
    int lat = 0;
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    fork
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      begin
        while (Count_Sig !== 1'b1 && lat < 10) begin
          @(negedge CLK);
          lat++;
        end
      end
    join
    checks++;
    if (lat < 1 || lat > 3) begin
      errors++;
      $display("FAIL count_sig_latency: got %0d cycles, required 1..3", lat);
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (done_cnt - d0 !== 1 || ferr_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL basic_pulses: got done=%0d ferr=%0d, required done=1 ferr=0", done_cnt - d0, ferr_cnt - f0);
    end
    checks++;
    if (RX_Data !== 8'h55) begin
      errors++;
      $display("FAIL basic_data_hold: got %h, required 55", RX_Data);
    end
  endtask

  task automatic test_false_start;
    RX_Pin_In = 1'b0;
    repeat (100) @(negedge CLK);
    checks++;
    if (Count_Sig !== 1'b1) begin
      errors++;
      $display("FAIL glitch_count_rise: got %b, required 1", Count_Sig);
    end
    RX_Pin_In = 1'b1;
    repeat (50) @(negedge CLK);
    checks++;
    if (Count_Sig !== 1'b0) begin
      errors++;
      $display("FAIL glitch_count_drop: got %b, required 0", Count_Sig);
    end
    checks++;
    if (RX_Data !== model_data || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_no_effect: got data=%h pending=%0d, required data=%h pending=0",
               RX_Data, exp_q.size(), model_data);
    end
    repeat (BIT_CYC) @(negedge CLK);
  endtask

  task automatic test_frame_err;
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
    repeat (BIT_CYC) @(negedge CLK);
    checks++;
    if (ferr_cnt - f0 !== 1 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL frame_err_pulses: got ferr=%0d done=%0d, required ferr=1 done=0", ferr_cnt - f0, done_cnt - d0);
    end
    checks++;
    if (RX_Data !== 8'h55) begin
      errors++;
      $display("FAIL frame_err_data: got %h, required 55", RX_Data);
    end
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3*BIT_CYC && exp_q.size() != 0; i++) @(negedge CLK);
    checks++;
    if (done_cnt - d0 !== 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got done=%0d pending=%0d, required done=2 pending=0", done_cnt - d0, exp_q.size());
    end
    repeat (BIT_CYC) @(negedge CLK);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'hF0;
    RX_Pin_In = 1'b0;
    repeat (BIT_CYC) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX_Pin_In = d[i];
      repeat (BIT_CYC) @(negedge CLK);
    end
    RX_Pin_In = d[4];
    repeat (BIT_CYC/2) @(negedge CLK);
    RSTn = 1'b0;
    model_data = 8'h00;
    repeat (3) @(negedge CLK);
    checks++;
    if ({Count_Sig, RX_Done_Sig, Frame_Err, Parity_Err} !== 4'b0 || RX_Data !== 8'h00) begin
      errors++;
      $display("FAIL midframe_reset: got cs=%b done=%b ferr=%b perr=%b data=%h, required all 0",
               Count_Sig, RX_Done_Sig, Frame_Err, Parity_Err, RX_Data);
    end
    RX_Pin_In = 1'b1;
    RSTn = 1'b1;
    repeat (2*BIT_CYC) @(negedge CLK);
    checks++;
    if (Count_Sig !== 1'b0 || RX_Data !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle: got cs=%b data=%h, required cs=0 data=00", Count_Sig, RX_Data);
    end
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    checks++;
    if (RX_Data !== 8'h0F || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_frame: got %h pending=%0d, required 0F pending=0", RX_Data, exp_q.size());
    end
  endtask

  task automatic test_rx_disabled;
    int d0 = done_cnt;
    int busy = 0;
    RX_En = 1'b0;
    fork
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10*BIT_CYC; i++) begin
        @(negedge CLK);
        if (Count_Sig) busy++;
      end
    join
    RX_En = 1'b1;
    repeat (20) @(negedge CLK);
    checks++;
    if (busy != 0 || done_cnt != d0 || RX_Data !== 8'h0F) begin
      errors++;
      $display("FAIL rx_disabled: got busy=%0d done=%0d data=%h, required 0/0/0F", busy, done_cnt - d0, RX_Data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);   // parity bit 1: good
    repeat (20) @(negedge CLK);
    checks++;
    if (RX_Data !== 8'h07) begin
      errors++;
      $display("FAIL parity_good: got %h, required 07", RX_Data);
    end
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);   // parity bit 0: mismatch
    send_frame(8'h07, 1'b0, 1'b1, 1'b1);   // bad parity + low stop: frame error wins
    repeat (20) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0 || RX_Data !== 8'h07) begin
      errors++;
      $display("FAIL parity_err: got pending=%0d data=%h, required 0 and 07", exp_q.size(), RX_Data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_rx_disabled();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (20) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive control stage that sits directly downstream of the RX baud-rate generator. It detects the start bit on the serial line and raises Count_Sig to start the baud counter. It then consumes the mid-bit BPS_CLK pulses to sample start, data and stop bits, and presents the received byte with a one-cycle done strobe. Target system: 50 MHz CLK, 9600 baud, 5208 CLK cycles per bit, mid-bit pulse 2604 cycles after Count_Sig rises.

Parameters:
DATA_BITS, 8, number of data bits per frame, sent LSB first
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
RX_Pin_In  input  1  raw serial line, asynchronous, idles high
RX_En  input  1  receive enable; gates start-bit acceptance only
BPS_CLK  input  1  one-cycle mid-bit pulse from the baud generator
Count_Sig  output  1  high while a frame is in progress; enables the baud counter
RX_Data  output  DATA_BITS  last correctly received byte
RX_Done_Sig  output  1  one-cycle pulse when RX_Data is updated
Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low
Parity_Err  output  1  one-cycle pulse on parity mismatch

Behaviour:
- Reset: all outputs are 0; FSM in IDLE; synchronizer flops are 1; shift register and bit counter are 0.
- RX_Pin_In passes through a 2-flop synchronizer and then a registered falling-edge detector (H2L). H2L is asserted the cycle the synchronized line goes from 1 to 0.
- IDLE: Count_Sig=0. If H2L && RX_En, go to START and set Count_Sig=1 on the next edge. H2L is ignored in every other state.
- START: on BPS_CLK, sample the synchronized line.
  - Line = 1: false start. Return to IDLE and set Count_Sig=0. No strobe is generated.
  - Line = 0: go to DATA with the bit counter at 0.
- DATA: on each BPS_CLK, shift the sample into the MSB of the shift register (right shift), so bit 0 is first received. Increment the bit counter. After the DATA_BITS-th sample, go to PARITY if the feature is enabled, otherwise go to STOP.
- STOP: on BPS_CLK, sample the line.
  - Sample 1 and no parity error: load RX_Data from the shift register and pulse RX_Done_Sig for exactly 1 cycle.
  - Sample 0: pulse Frame_Err for 1 cycle and leave RX_Data unchanged.
  - In both cases go to IDLE and set Count_Sig=0 in the same cycle as the strobe.
- Latency: RX_Done_Sig rises on the clock edge following the BPS_CLK cycle that samples the stop bit.
- Count_Sig deasserts at mid-stop-bit. The baud counter therefore clears, and the next falling edge (start bit) is caught with no dead time.
- BPS_CLK arriving in IDLE is ignored.
- RX_En deasserted mid-frame: the frame completes normally. RX_En asserted mid-frame has no effect until IDLE.
- RSTn asserted mid-frame: immediate return to reset state. A partial byte is discarded and no strobe is generated.
- Bit counter width is clog2(DATA_BITS+1). It clears on entry to DATA and never wraps within a frame.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state follows DATA. On BPS_CLK it samples the parity bit and compares it against the XOR of the data bits (XOR'd with PARITY_ODD), then goes to STOP.
  - Mismatch: in STOP, Parity_Err pulses for 1 cycle in place of RX_Done_Sig, and RX_Data is unchanged.
  - A low stop bit produces Frame_Err only, taking priority over Parity_Err.
- Undefined: no PARITY state exists, and Parity_Err is tied to 0.

Test Plan:
- Bench setup: DUT paired with a 5208-cycle baud generator, driving 9600-baud frames at 50 MHz.
- Idle line high, RX_En=1, send frame 0x55 -> Count_Sig high from 1-3 cycles after the start edge until the stop sample; RX_Data=0x55; RX_Done_Sig high exactly 1 cycle; Frame_Err=0.
- Low glitch of 100 cycles on an idle line -> START sample reads 1; back to IDLE; Count_Sig drops; no RX_Done_Sig; RX_Data unchanged.
- Frame 0xA3 with stop bit held low -> Frame_Err 1-cycle pulse; RX_Done_Sig=0; RX_Data keeps its previous value (0x55).
- Back-to-back frames 0xA5 then 0x3C with no idle gap -> two RX_Done_Sig pulses; RX_Data=0xA5 then 0x3C; no missed start bit.
- RSTn pulsed low during data bit 4 of 0xF0, then frame 0x0F sent -> all outputs 0 after reset; only 0x0F is reported; RX_En=0 during a full frame -> no strobe.
- UART_RX_PARITY_EN with PARITY_ODD=0: frame 0x07 with parity bit 1 -> RX_Done_Sig and RX_Data=0x07; the same frame with parity bit 0 -> Parity_Err 1-cycle pulse and RX_Data unchanged.
